// File: rtl/wb_arb2.sv
// wb_arb2: two-master Wishbone arbiter with round-robin fairness.
// Master 0 is the CPU, master 1 is the DMA / video fetch. The grant is held
// from the first strobe until the slave acknowledges or the master aborts.
// On an acknowledge the grant can move to the other master with no dead cycle.
// Optional feature macro: WB_ARB_TIMEOUT_EN. When it is defined, a watchdog
// completes a stalled transfer after TO_CYCLES cycles and sets a sticky err_o.
module wb_arb2 #(
  parameter int TO_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // master 0 (CPU)
  input  logic [19:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  input  logic        m0_we_i,
  input  logic        m0_mio_i,
  input  logic        m0_byte_i,
  input  logic        m0_stb_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  // master 1 (DMA)
  input  logic [19:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic        m1_mio_i,
  input  logic        m1_byte_i,
  input  logic        m1_stb_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  // slave side
  output logic [19:0] s_adr_o,
  output logic [15:0] s_dat_o,
  output logic        s_we_o,
  output logic        s_mio_o,
  output logic        s_byte_o,
  output logic        s_stb_o,
  input  logic [15:0] s_dat_i,
  input  logic        s_ack_i,
  // status
  output logic [1:0]  gnt_o,
  output logic        err_o
);

  // The encoding doubles as the one-hot grant, so gnt_o is a plain register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_G0   = 2'b01,
    ST_G1   = 2'b10
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   last_r;
  logic   last_nxt_s;
  logic   to_hit_s;
  logic   done_s;

  // Reject watchdog limits that do not fit the 8-bit counter.
  if ((TO_CYCLES < 1) || (TO_CYCLES > 255)) begin : g_bad_to_cycles
    $error("wb_arb2: TO_CYCLES must be 1..255");
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST_C = 8'(TO_CYCLES - 1);

  logic [7:0] cnt_r;
  logic       err_r;

  // The counter holds the number of cycles already waited, so it fires on
  // cycle TO_CYCLES of a wait. A real ack in the same cycle takes precedence.
  assign to_hit_s = (state_r != ST_IDLE) && !s_ack_i && (cnt_r == TO_LAST_C);
  assign err_o    = err_r;

  // Watchdog counter: restart on any grant change or completion, count while granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= 8'd0;
    end else if ((state_nxt_s != state_r) || s_ack_i || to_hit_s) begin
      cnt_r <= 8'd0;
    end else if (state_r != ST_IDLE) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (to_hit_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  assign to_hit_s = 1'b0;
  assign err_o    = 1'b0;
`endif

  // A transfer completes on a slave ack or on a watchdog expiry.
  assign done_s = s_ack_i | to_hit_s;

  // State and round-robin history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
    end
  end

  // Next-state logic: arbitrate in IDLE, hand over or release on completion or abort.
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (m0_stb_i && m1_stb_i) begin
          state_nxt_s = last_r ? ST_G0 : ST_G1;
        end else if (m0_stb_i) begin
          state_nxt_s = ST_G0;
        end else if (m1_stb_i) begin
          state_nxt_s = ST_G1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_G0: begin
        if (done_s) begin
          last_nxt_s = 1'b0;
          if (m1_stb_i) begin
            state_nxt_s = ST_G1;
          end else if (m0_stb_i) begin
            state_nxt_s = ST_G0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (!m0_stb_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_G0;
        end
      end
      ST_G1: begin
        if (done_s) begin
          last_nxt_s = 1'b1;
          if (m0_stb_i) begin
            state_nxt_s = ST_G0;
          end else if (m1_stb_i) begin
            state_nxt_s = ST_G1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (!m1_stb_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_G1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        last_nxt_s  = 1'b1;
      end
    endcase
  end

  // Slave-side request mux: granted master's signals, all zero when idle.
  always_comb begin
    s_adr_o  = 20'h00000;
    s_dat_o  = 16'h0000;
    s_we_o   = 1'b0;
    s_mio_o  = 1'b0;
    s_byte_o = 1'b0;
    s_stb_o  = 1'b0;
    case (state_r)
      ST_G0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_we_o   = m0_we_i;
        s_mio_o  = m0_mio_i;
        s_byte_o = m0_byte_i;
        s_stb_o  = m0_stb_i;
      end
      ST_G1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_we_o   = m1_we_i;
        s_mio_o  = m1_mio_i;
        s_byte_o = m1_byte_i;
        s_stb_o  = m1_stb_i;
      end
      default: begin
        s_stb_o  = 1'b0;
      end
    endcase
  end

  // Ack goes only to the owner, combinationally; read data is broadcast.
  assign m0_ack_o = done_s && (state_r == ST_G0);
  assign m1_ack_o = done_s && (state_r == ST_G1);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = state_r;

endmodule
